// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming MIPS-subset instruction encoder
//
// Accepts one mnemonic plus operand fields per handshake and emits the
// encoded 32-bit word(s) with sequential word addresses, ready to be written
// into instruction memory. BLT/BGE pseudo-instructions expand to SLT followed
// by BNE/BEQ through a scratch register.
//
// Ports:
//   clk, rstN             clock (rising edge), asynchronous active-low reset
//   inValid / inReady     request handshake; inReady is high only in IDLE
//   mnemonic              0 LW 1 SW 2 J 3 JAL 4 BEQ 5 BNE 6 XORI 7 ADDI
//                         8 ADD 9 SUB 10 SLT 11 JR 12 NOP 13 MOVE 14 BLT 15 BGE
//   rdIn, rsIn, rtIn      register fields
//   immIn, targetIn       immediate / branch offset, jump target
//   outValid / outReady   output word handshake
//   instrOut, pcOut       encoded word and its word address
//   pcLoad, pcLoadVal     address counter load, honoured only in IDLE
//   err                   one-cycle pulse when a request is rejected
module instr_encoder #(
  parameter int ADDR_W   = 10,
  parameter int TEMP_REG = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [3:0]        mnemonic,
  input  logic [4:0]        rdIn,
  input  logic [4:0]        rsIn,
  input  logic [4:0]        rtIn,
  input  logic [15:0]       immIn,
  input  logic [25:0]       targetIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [31:0]       instrOut,
  output logic [ADDR_W-1:0] pcOut,
  input  logic              pcLoad,
  input  logic [ADDR_W-1:0] pcLoadVal,
  output logic              err
);

  localparam logic [4:0] TEMP = TEMP_REG[4:0];

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] word2;
  logic        two_word;

  // Combinational encode of the request currently on the inputs
  logic [31:0] enc_w1;
  logic [31:0] enc_w2;
  logic        enc_two;
  logic        enc_bad;
  logic [15:0] imm_m1;
  logic [31:0] slt_tmp;

  // Pseudo branches sit one word earlier than the real branch, so the
  // offset relative to the branch itself is one less.
  assign imm_m1  = immIn - 16'd1;
  assign slt_tmp = {OP_RTYPE, rsIn, rtIn, TEMP, 5'd0, FN_SLT};

  always_comb begin
    enc_w1  = '0;
    enc_w2  = '0;
    enc_two = 1'b0;
    enc_bad = 1'b0;
    case (mnemonic)
      4'd0:  enc_w1 = {OP_LW,   rsIn, rtIn, immIn};
      4'd1:  enc_w1 = {OP_SW,   rsIn, rtIn, immIn};
      4'd2:  enc_w1 = {OP_J,    targetIn};
      4'd3:  enc_w1 = {OP_JAL,  targetIn};
      4'd4:  enc_w1 = {OP_BEQ,  rsIn, rtIn, immIn};
      4'd5:  enc_w1 = {OP_BNE,  rsIn, rtIn, immIn};
      4'd6:  enc_w1 = {OP_XORI, rsIn, rtIn, immIn};
      4'd7:  enc_w1 = {OP_ADDI, rsIn, rtIn, immIn};
      4'd8:  enc_w1 = {OP_RTYPE, rsIn, rtIn, rdIn, 5'd0, FN_ADD};
      4'd9:  enc_w1 = {OP_RTYPE, rsIn, rtIn, rdIn, 5'd0, FN_SUB};
      4'd10: enc_w1 = {OP_RTYPE, rsIn, rtIn, rdIn, 5'd0, FN_SLT};
      4'd11: enc_w1 = {OP_RTYPE, rsIn, 5'd0, 5'd0, 5'd0, FN_JR};
      4'd12: enc_w1 = {OP_RTYPE, 5'd0, 5'd0, 5'd0, 5'd0, FN_ADD};
      4'd13: enc_w1 = {OP_RTYPE, rsIn, 5'd0, rdIn, 5'd0, FN_ADD};
      4'd14: begin
        enc_w1  = slt_tmp;
        enc_w2  = {OP_BNE, TEMP, 5'd0, imm_m1};
        enc_two = 1'b1;
        enc_bad = (immIn == 16'h8000);
      end
      default: begin
        enc_w1  = slt_tmp;
        enc_w2  = {OP_BEQ, TEMP, 5'd0, imm_m1};
        enc_two = 1'b1;
        enc_bad = (immIn == 16'h8000);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      instrOut <= '0;
      pcOut    <= '0;
      err      <= 1'b0;
      word2    <= '0;
      two_word <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (pcLoad) begin
            pcOut <= pcLoadVal;
          end
          if (inValid) begin
            if (enc_bad) begin
              // Offset underflow: swallow the request, stay ready
              err <= 1'b1;
            end else begin
              instrOut <= enc_w1;
              word2    <= enc_w2;
              two_word <= enc_two;
              outValid <= 1'b1;
              inReady  <= 1'b0;
              state    <= SEND1;
            end
          end
        end
        SEND1: begin
          if (outReady) begin
            pcOut <= pcOut + 1'b1;
            if (two_word) begin
              instrOut <= word2;
              state    <= SEND2;
            end else begin
              outValid <= 1'b0;
              inReady  <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        SEND2: begin
          if (outReady) begin
            pcOut    <= pcOut + 1'b1;
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          outValid <= 1'b0;
          inReady  <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [3:0]    mnemonic = '0;
  logic [4:0]    rdIn = '0;
  logic [4:0]    rsIn = '0;
  logic [4:0]    rtIn = '0;
  logic [15:0]   immIn = '0;
  logic [25:0]   targetIn = '0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [31:0]   instrOut;
  logic [AW-1:0] pcOut;
  logic          pcLoad = 1'b0;
  logic [AW-1:0] pcLoadVal = '0;
  logic          err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .TEMP_REG(1)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .mnemonic(mnemonic), .rdIn(rdIn), .rsIn(rsIn), .rtIn(rtIn),
    .immIn(immIn), .targetIn(targetIn), .outValid(outValid),
    .outReady(outReady), .instrOut(instrOut), .pcOut(pcOut),
    .pcLoad(pcLoad), .pcLoadVal(pcLoadVal), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expected (word, address) pairs in emission order
  typedef struct {
    logic [31:0] w;
    int          pc;
  } exp_t;

  exp_t q[$];
  int   mpc = 0;

  function automatic logic [31:0] rtype(longint rs, longint rt, longint rd, longint fn);
    return 32'(rs * 2**21 + rt * 2**16 + rd * 2**11 + fn);
  endfunction

  function automatic logic [31:0] itype(longint op, longint rs, longint rt, longint imm);
    return 32'(op * 2**26 + rs * 2**21 + rt * 2**16 + imm);
  endfunction

  function automatic logic [31:0] jtype(longint op, longint tgt);
    return 32'(op * 2**26 + tgt);
  endfunction

  task automatic push(input logic [31:0] w);
    q.push_back('{w, mpc});
    mpc = (mpc + 1) % (1 << AW);
  endtask

  task automatic model(input int mn, input int rd, input int rs, input int rt,
                       input int imm, input int tgt, output bit bad);
    bad = 1'b0;
    case (mn)
      0:  push(itype(35, rs, rt, imm));
      1:  push(itype(43, rs, rt, imm));
      2:  push(jtype(2, tgt));
      3:  push(jtype(3, tgt));
      4:  push(itype(4, rs, rt, imm));
      5:  push(itype(5, rs, rt, imm));
      6:  push(itype(14, rs, rt, imm));
      7:  push(itype(8, rs, rt, imm));
      8:  push(rtype(rs, rt, rd, 32));
      9:  push(rtype(rs, rt, rd, 34));
      10: push(rtype(rs, rt, rd, 42));
      11: push(rtype(rs, 0, 0, 8));
      12: push(32'h0000_0020);
      13: push(rtype(rs, 0, rd, 32));
      default: begin
        if (imm == 32768) begin
          bad = 1'b1;
        end else begin
          push(rtype(rs, rt, 1, 42));
          push(itype((mn == 14) ? 5 : 4, 1, 0, (imm + 65535) % 65536));
        end
      end
    endcase
  endtask

  // Sink ready: 0 always ready, 1 random, 2 stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       outReady = 1'b1;
      1:       outReady = ($urandom % 3) != 0;
      default: outReady = 1'b0;
    endcase
  end

  // Output monitor: scoreboard compare plus stability under back-pressure
  bit            hold = 1'b0;
  logic [31:0]   hold_instr;
  logic [AW-1:0] hold_pc;
  always @(negedge clk) begin
    if (!rstN) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 32'(outValid), 32'(1));
        chk("stall_instr", instrOut, hold_instr);
        chk("stall_pc", 32'(pcOut), 32'(hold_pc));
      end
      if (outValid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(outValid), 32'(0));
        end else begin
          chk("instr", instrOut, q[0].w);
          chk("pc", 32'(pcOut), 32'(q[0].pc));
          if (outReady) void'(q.pop_front());
        end
      end
      hold       = outValid && !outReady;
      hold_instr = instrOut;
      hold_pc    = pcOut;
    end
  end

  task automatic req(input int mn, input int rd, input int rs, input int rt,
                     input int imm, input int tgt, input bit ld, input int ldv);
    bit bad;
    @(posedge clk);
    #1;
    inValid   = 1'b1;
    mnemonic  = 4'(mn);
    rdIn      = 5'(rd);
    rsIn      = 5'(rs);
    rtIn      = 5'(rt);
    immIn     = 16'(imm);
    targetIn  = 26'(tgt);
    pcLoad    = ld;
    pcLoadVal = AW'(ldv);
    if (ld) mpc = ldv;
    model(mn, rd, rs, rt, imm, tgt, bad);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    pcLoad  = 1'b0;
    @(negedge clk);
    chk("err_pulse", 32'(err), 32'(bad));
    chk("in_ready_after_accept", 32'(inReady), 32'(bad));
    chk("latency_valid", 32'(outValid), 32'(!bad));
    if (bad) begin
      @(negedge clk);
      chk("err_clear", 32'(err), 32'(0));
      chk("err_pc_hold", 32'(pcOut), 32'(mpc));
    end
  endtask

  // Drain pending words; pcLoad is wiggled while busy and must be ignored
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(inReady && q.size() == 0) && n < 60) begin
      pcLoad    = !inReady && (($urandom % 4) == 0);
      pcLoadVal = AW'($urandom);
      @(negedge clk);
      n++;
    end
    pcLoad = 1'b0;
    if (n >= 60) begin
      chk("drain_timeout", 32'(inReady && q.size() == 0), 32'(1));
      q.delete();
    end
  endtask

  initial begin
    int mn;
    int imm;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(inReady), 32'(1));
    chk("rst_out_valid", 32'(outValid), 32'(0));
    chk("rst_instr", instrOut, 32'h0);
    chk("rst_pc", 32'(pcOut), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rstN = 1'b1;
    mpc  = 0;

    req(8, 3, 1, 2, 0, 0, 1'b0, 0);
    wait_idle();
    req(7, 0, 0, 8, 5, 0, 1'b1, 0);
    wait_idle();
    req(0, 0, 29, 9, 8, 0, 1'b0, 0);
    wait_idle();
    req(14, 0, 4, 5, 3, 0, 1'b0, 0);
    wait_idle();
    req(15, 0, 4, 5, 3, 0, 1'b0, 0);
    wait_idle();

    rdy_mode = 2;
    req(2, 0, 0, 0, 0, 26'h100000, 1'b0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(inReady), 32'(0));
    end
    rdy_mode = 0;
    wait_idle();

    req(3, 0, 0, 0, 0, 3, 1'b1, 10'h3FF);
    wait_idle();
    req(12, 7, 7, 7, 7, 7, 1'b0, 0);
    wait_idle();

    req(14, 0, 4, 5, 16'h8000, 0, 1'b0, 0);
    wait_idle();
    req(15, 0, 6, 2, 16'h8000, 0, 1'b0, 0);
    wait_idle();

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      mn  = int'($urandom % 16);
      imm = (($urandom % 6) == 0) ? 32768 : int'($urandom % 65536);
      req(mn, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), imm,
          int'($urandom % (1 << 26)), ($urandom % 8) == 0, int'($urandom % (1 << AW)));
      wait_idle();
    end

    rdy_mode = 0;
    req(14, 0, 9, 10, 100, 0, 1'b0, 0);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("async_rst_valid", 32'(outValid), 32'(0));
    chk("async_rst_pc", 32'(pcOut), 32'(0));
    chk("async_rst_in_ready", 32'(inReady), 32'(1));
    @(negedge clk);
    mpc = 0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    req(13, 4, 5, 0, 0, 0, 1'b0, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming MIPS-subset instruction encoder, the inverse of the core's instruction decoder. It accepts one mnemonic plus operand fields per handshake and emits 32-bit instruction words with sequential word addresses, for writing into instruction memory. It also expands the BLT and BGE pseudo-instructions into two words each. It sits between the test or boot program source and the instruction-memory write port.

Parameters:
ADDR_W, 10, width of the emitted word address pcOut
TEMP_REG, 1, register used as scratch by the BLT/BGE expansion

Ports:
clk  input  1  clock, rising edge
rstN  input  1  reset, asynchronous, active-low
inValid  input  1  request valid
inReady  output  1  encoder can accept a request
mnemonic  input  4  0 LW, 1 SW, 2 J, 3 JAL, 4 BEQ, 5 BNE, 6 XORI, 7 ADDI, 8 ADD, 9 SUB, 10 SLT, 11 JR, 12 NOP, 13 MOVE, 14 BLT, 15 BGE
rdIn  input  5  destination register (R-type)
rsIn  input  5  source register / base
rtIn  input  5  second source, or I-type destination
immIn  input  16  immediate / branch word offset relative to pseudo address+1
targetIn  input  26  jump target field
outValid  output  1  instrOut/pcOut valid
outReady  input  1  sink accepts word
instrOut  output  32  encoded instruction word
pcOut  output  ADDR_W  word address of instrOut
pcLoad  input  1  load address counter
pcLoadVal  input  ADDR_W  value for pcLoad
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (rstN low, asynchronous): state IDLE, inReady=1, outValid=0, instrOut=0, pcOut=0, err=0. Any pending word is discarded.
- States: IDLE, SEND1, SEND2. inReady=1 only in IDLE.
- IDLE, inValid=1: request accepted. Word(s) computed and registered.
  - Next cycle: SEND1 with outValid=1. Latency is 1 cycle.
- SEND1, outReady=1: word consumed and pcOut increments by 1.
  - Two-word request: go to SEND2, second word presented next cycle.
  - Otherwise: go to IDLE.
- SEND2, outReady=1: pcOut increments by 1, go to IDLE.
- While outReady=0: instrOut and pcOut stay stable.
- pcOut wraps from 2^ADDR_W-1 to 0 with no error.
- pcLoad is honoured only in IDLE and is ignored otherwise.
  - pcLoad in the same cycle as an accept: the loaded value is the address of the first emitted word.
- Encodings:
  - R-type: {6'h00, rs, rt, rd, 5'h00, funct}.
  - I-type: {opcode, rs, rt, imm}.
  - J-type: {opcode, target}.
- Opcodes: LW 23, SW 2b, J 02, JAL 03, BEQ 04, BNE 05, XORI 0e, ADDI 08.
- Functs: ADD 20, SUB 22, SLT 2a, JR 08.
- JR: rt=rd=0.
- NOP: ADD $0,$0,$0 = 0x00000020.
- MOVE: ADD rdIn, rsIn, $0.
- BLT: SLT TEMP_REG, rsIn, rtIn; then BNE TEMP_REG, $0, immIn-1.
- BGE: SLT TEMP_REG, rsIn, rtIn; then BEQ TEMP_REG, $0, immIn-1.
- BLT/BGE with immIn=16'h8000 (imm-1 underflow):
  - Request is accepted (inReady was 1) but nothing is emitted and pcOut is unchanged.
  - err pulses 1 the cycle after the accept; state stays IDLE.
- Unused fields are ignored: rdIn for I-type/J-type, targetIn for non-jumps.

Test Plan:
- Reset, then ADD rd=3 rs=1 rt=2 with outReady=1 -> instrOut=0x00221820 at pcOut=0, one cycle after accept; inReady returns to 1 next cycle.
- ADDI rt=8 rs=0 imm=5, then LW rt=9 rs=29 imm=8 -> 0x20080005 at pcOut 0, then 0x8FA90008 at pcOut 1.
- BLT rs=4 rt=5 imm=3 -> 0x0085082A at pcOut n, then 0x14200002 at pcOut n+1. Repeat with BGE -> second word 0x10200002.
- J target 0x100000 with outReady held 0 for 5 cycles -> instrOut=0x08100000 stable; inReady=0 throughout; pcOut increments only after outReady rises.
- pcLoad=1, pcLoadVal=0x3FF with JAL target 3, then NOP -> 0x0C000003 at 0x3FF, then 0x00000020 at 0x000 (wrap).
- BLT imm=0x8000 -> err pulse, no outValid, pcOut unchanged. Separately, assert rstN low while in SEND2 -> outValid=0, pcOut=0 immediately.
